// File: rtl/cprv_ex_stage_if.sv
// Pipeline bus around the EX stage: the ID->EX request side and the EX->MEM result side.
// The slave modport is the EX stage's view; master is the surrounding pipeline's view.
interface cprv_ex_stage_if #(
    parameter int DATA_WIDTH = 64
);
    logic                  valid_ex_i;
    logic                  ready_ex_o;
    logic [DATA_WIDTH-1:0] rs1_data_ex_i;
    logic [DATA_WIDTH-1:0] rs2_data_ex_i;
    logic [4:0]            rd_addr_ex_i;
    logic                  rd_en_ex_i;
    logic [DATA_WIDTH-1:0] imm_data_ex_i;
    logic [6:0]            opcode_ex_i;
    logic [2:0]            funct3_ex_i;
    logic [6:0]            funct7_ex_i;
    logic                  mem_w_en_ex_i;

    logic                  valid_mem_o;
    logic                  ready_mem_i;
    logic [DATA_WIDTH-1:0] alu_data_mem_o;
    logic [DATA_WIDTH-1:0] store_data_mem_o;
    logic [4:0]            rd_addr_mem_o;
    logic                  rd_en_mem_o;
    logic                  mem_w_en_mem_o;
    logic                  mem_r_en_mem_o;
    logic [2:0]            funct3_mem_o;

    modport slave (
        input  valid_ex_i, rs1_data_ex_i, rs2_data_ex_i, rd_addr_ex_i, rd_en_ex_i,
               imm_data_ex_i, opcode_ex_i, funct3_ex_i, funct7_ex_i, mem_w_en_ex_i,
               ready_mem_i,
        output ready_ex_o, valid_mem_o, alu_data_mem_o, store_data_mem_o,
               rd_addr_mem_o, rd_en_mem_o, mem_w_en_mem_o, mem_r_en_mem_o, funct3_mem_o
    );

    modport master (
        output valid_ex_i, rs1_data_ex_i, rs2_data_ex_i, rd_addr_ex_i, rd_en_ex_i,
               imm_data_ex_i, opcode_ex_i, funct3_ex_i, funct7_ex_i, mem_w_en_ex_i,
               ready_mem_i,
        input  ready_ex_o, valid_mem_o, alu_data_mem_o, store_data_mem_o,
               rd_addr_mem_o, rd_en_mem_o, mem_w_en_mem_o, mem_r_en_mem_o, funct3_mem_o
    );
endinterface

// File: rtl/cprv_ex_stage.sv
// RV64 execute stage: single-cycle ALU/address generation with registered MEM outputs.
// Define CPRV_EX_MUL_EN to add an iterative shift-add MUL/MULW unit.
module cprv_ex_stage #(
    parameter int DATA_WIDTH = 64
) (
    input logic           clk,
    input logic           rst,
    cprv_ex_stage_if.slave ex_if
);
    localparam int SHW = $clog2(DATA_WIDTH);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM32  = 7'b0011011;
    localparam logic [6:0] OP_OP32   = 7'b0111011;

    function automatic logic [DATA_WIDTH-1:0] sext32(input logic [31:0] v);
        return {{(DATA_WIDTH-32){v[31]}}, v};
    endfunction

    logic                  valid_q;
    logic [DATA_WIDTH-1:0] alu_q, store_q;
    logic [4:0]            rd_addr_q;
    logic                  rd_en_q, mem_w_q, mem_r_q;
    logic [2:0]            funct3_q;

    logic                  cke, idle, xfer;
    logic                  mul_start, mul_done;
    logic [DATA_WIDTH-1:0] mul_res;
    logic [DATA_WIDTH-1:0] op_a, op_b, alu_res;
    logic [SHW-1:0]        sh;
    logic [31:0]           w_res;
    logic                  alt, is_op, is_op32;

    assign cke  = ~valid_q | ex_if.ready_mem_i;
    assign xfer = ex_if.valid_ex_i & ex_if.ready_ex_o;
    assign ex_if.ready_ex_o = cke & idle;

    assign is_op   = (ex_if.opcode_ex_i == OP_OP);
    assign is_op32 = (ex_if.opcode_ex_i == OP_OP32);
    assign alt     = ex_if.funct7_ex_i[5];
    assign op_a    = ex_if.rs1_data_ex_i;
    assign op_b    = (is_op | is_op32) ? ex_if.rs2_data_ex_i : ex_if.imm_data_ex_i;
    assign sh      = op_b[SHW-1:0];

    always_comb begin
        alu_res = '0;
        w_res   = '0;
        case (ex_if.opcode_ex_i)
            OP_OP, OP_OPIMM: begin
                case (ex_if.funct3_ex_i)
                    3'b000:  alu_res = (is_op & alt) ? op_a - op_b : op_a + op_b;
                    3'b001:  alu_res = op_a << sh;
                    3'b010:  alu_res = {{(DATA_WIDTH-1){1'b0}}, $signed(op_a) < $signed(op_b)};
                    3'b011:  alu_res = {{(DATA_WIDTH-1){1'b0}}, op_a < op_b};
                    3'b100:  alu_res = op_a ^ op_b;
                    3'b101:  alu_res = alt ? DATA_WIDTH'($signed(op_a) >>> sh) : op_a >> sh;
                    3'b110:  alu_res = op_a | op_b;
                    default: alu_res = op_a & op_b;
                endcase
            end
            OP_OP32, OP_IMM32: begin
                case (ex_if.funct3_ex_i)
                    3'b000: begin
                        w_res   = (is_op32 & alt) ? op_a[31:0] - op_b[31:0] : op_a[31:0] + op_b[31:0];
                        alu_res = sext32(w_res);
                    end
                    3'b001: begin
                        w_res   = op_a[31:0] << op_b[4:0];
                        alu_res = sext32(w_res);
                    end
                    3'b101: begin
                        w_res   = alt ? 32'($signed(op_a[31:0]) >>> op_b[4:0]) : op_a[31:0] >> op_b[4:0];
                        alu_res = sext32(w_res);
                    end
                    default: alu_res = '0;
                endcase
            end
            OP_LOAD, OP_STORE: alu_res = op_a + ex_if.imm_data_ex_i;
            default:           alu_res = '0;
        endcase
`ifdef CPRV_EX_MUL_EN
        if ((is_op | is_op32) && ex_if.funct7_ex_i == 7'b0000001 && ex_if.funct3_ex_i != 3'b000)
            alu_res = '0;
`endif
    end

`ifdef CPRV_EX_MUL_EN
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] ma_q, mb_q, acc_q;
    logic [SHW-1:0]        cnt_q;
    logic                  w_q, mul_last;

    assign mul_start = xfer & (is_op | is_op32) & (ex_if.funct7_ex_i == 7'b0000001)
                     & (ex_if.funct3_ex_i == 3'b000);
    assign mul_last  = (cnt_q == (w_q ? SHW'(31) : SHW'(DATA_WIDTH-1)));
    assign mul_done  = (state_q == DONE);
    assign idle      = (state_q == IDLE);
    assign mul_res   = w_q ? sext32(acc_q[31:0]) : acc_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (mul_start) state_d = BUSY;
            BUSY:    if (mul_last)  state_d = DONE;
            DONE:    if (cke)       state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ma_q    <= '0;
            mb_q    <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            w_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (mul_start) begin
                ma_q  <= ex_if.rs1_data_ex_i;
                mb_q  <= ex_if.rs2_data_ex_i;
                acc_q <= '0;
                cnt_q <= '0;
                w_q   <= is_op32;
            end else if (state_q == BUSY) begin
                if (mb_q[0]) acc_q <= acc_q + ma_q;
                ma_q  <= ma_q << 1;
                mb_q  <= mb_q >> 1;
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end
`else
    assign mul_start = 1'b0;
    assign mul_done  = 1'b0;
    assign idle      = 1'b1;
    assign mul_res   = '0;
`endif

    // A multiply transfer latches its side-band fields now; its result lands from DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q   <= 1'b0;
            alu_q     <= '0;
            store_q   <= '0;
            rd_addr_q <= '0;
            rd_en_q   <= 1'b0;
            mem_w_q   <= 1'b0;
            mem_r_q   <= 1'b0;
            funct3_q  <= '0;
        end else if (cke) begin
            valid_q <= (xfer & ~mul_start) | mul_done;
            if (xfer) begin
                alu_q     <= alu_res;
                store_q   <= ex_if.rs2_data_ex_i;
                rd_addr_q <= ex_if.rd_addr_ex_i;
                rd_en_q   <= ex_if.rd_en_ex_i;
                mem_w_q   <= ex_if.mem_w_en_ex_i;
                mem_r_q   <= (ex_if.opcode_ex_i == OP_LOAD);
                funct3_q  <= ex_if.funct3_ex_i;
            end else if (mul_done) begin
                alu_q <= mul_res;
            end
        end
    end

    assign ex_if.valid_mem_o      = valid_q;
    assign ex_if.alu_data_mem_o   = alu_q;
    assign ex_if.store_data_mem_o = store_q;
    assign ex_if.rd_addr_mem_o    = rd_addr_q;
    assign ex_if.rd_en_mem_o      = rd_en_q;
    assign ex_if.mem_w_en_mem_o   = mem_w_q;
    assign ex_if.mem_r_en_mem_o   = mem_r_q;
    assign ex_if.funct3_mem_o     = funct3_q;
endmodule

// File: tb/tb_cprv_ex_stage.sv
// Directed self-checking bench for cprv_ex_stage; MUL checks are built when CPRV_EX_MUL_EN is defined.
module tb_cprv_ex_stage;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_OPIMM = 7'b0010011;
    localparam logic [6:0] OP_OP    = 7'b0110011;
    localparam logic [6:0] OP_IMM32 = 7'b0011011;
    localparam logic [6:0] OP_OP32  = 7'b0111011;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    cprv_ex_stage_if #(.DATA_WIDTH(64)) bus ();

    cprv_ex_stage #(.DATA_WIDTH(64)) dut (
        .clk   (clk),
        .rst   (rst),
        .ex_if (bus)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic setup(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [63:0] a, input logic [63:0] b, input logic [63:0] imm,
                         input logic [4:0] rd, input logic rden, input logic mw);
        bus.opcode_ex_i   = op;
        bus.funct3_ex_i   = f3;
        bus.funct7_ex_i   = f7;
        bus.rs1_data_ex_i = a;
        bus.rs2_data_ex_i = b;
        bus.imm_data_ex_i = imm;
        bus.rd_addr_ex_i  = rd;
        bus.rd_en_ex_i    = rden;
        bus.mem_w_en_ex_i = mw;
        bus.valid_ex_i    = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [63:0] a, input logic [63:0] b, input logic [63:0] imm);
        setup(op, f3, f7, a, b, imm, 5'd1, 1'b1, 1'b0);
        tick();
        bus.valid_ex_i = 1'b0;
    endtask

    initial begin
        bus.ready_mem_i = 1'b1;
        // Inputs active during reset must not leak into the outputs
        setup(OP_OP, 3'b000, 7'd0, 64'd9, 64'd9, 64'd9, 5'd7, 1'b1, 1'b1);
        tick();
        tick();
        chk("rst_valid", {63'd0, bus.valid_mem_o}, 64'd0);
        chk("rst_alu", bus.alu_data_mem_o, 64'd0);
        chk("rst_store", bus.store_data_mem_o, 64'd0);
        chk("rst_rd", {59'd0, bus.rd_addr_mem_o}, 64'd0);
        chk("rst_ready", {63'd0, bus.ready_ex_o}, 64'd1);
        bus.valid_ex_i = 1'b0;
        #2 rst = 1'b0;
        tick();

        // Back-to-back ADD then SUB
        setup(OP_OP, 3'b000, 7'b0000000, 64'd5, -64'sd7, 64'd0, 5'd1, 1'b1, 1'b0);
        tick();
        chk("add_alu", bus.alu_data_mem_o, 64'hFFFF_FFFF_FFFF_FFFE);
        chk("add_valid", {63'd0, bus.valid_mem_o}, 64'd1);
        setup(OP_OP, 3'b000, 7'b0100000, 64'd5, -64'sd7, 64'd0, 5'd1, 1'b1, 1'b0);
        tick();
        bus.valid_ex_i = 1'b0;
        chk("sub_alu", bus.alu_data_mem_o, 64'd12);
        chk("sub_valid", {63'd0, bus.valid_mem_o}, 64'd1);
        tick();
        chk("idle_valid", {63'd0, bus.valid_mem_o}, 64'd0);

        send(OP_IMM32, 3'b101, 7'b0100000, 64'h0000_0000_8000_0000, 64'd0, 64'd4);
        chk("sraiw", bus.alu_data_mem_o, 64'hFFFF_FFFF_F800_0000);
        send(OP_OP, 3'b011, 7'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0);
        chk("sltu", bus.alu_data_mem_o, 64'd0);
        send(OP_OP, 3'b010, 7'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0);
        chk("slt", bus.alu_data_mem_o, 64'd1);
        send(OP_OPIMM, 3'b001, 7'd0, 64'd1, 64'd0, 64'd63);
        chk("slli63", bus.alu_data_mem_o, 64'h8000_0000_0000_0000);
        send(OP_OPIMM, 3'b101, 7'd0, 64'h8000_0000_0000_0000, 64'd0, 64'd63);
        chk("srli63", bus.alu_data_mem_o, 64'd1);
        send(OP_OP, 3'b101, 7'b0100000, 64'h8000_0000_0000_0000, 64'd4, 64'd0);
        chk("sra", bus.alu_data_mem_o, 64'hF800_0000_0000_0000);
        send(OP_OP, 3'b000, 7'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0);
        chk("add_wrap", bus.alu_data_mem_o, 64'd0);
        send(OP_OP32, 3'b000, 7'd0, 64'h0000_0000_7FFF_FFFF, 64'd1, 64'd0);
        chk("addw_ovf", bus.alu_data_mem_o, 64'hFFFF_FFFF_8000_0000);
        send(OP_OP32, 3'b010, 7'd0, 64'd5, 64'd7, 64'd0);
        chk("op32_bad_f3", bus.alu_data_mem_o, 64'd0);
        send(OP_OP, 3'b110, 7'd0, 64'hF0F0, 64'h0F00, 64'd0);
        chk("or", bus.alu_data_mem_o, 64'hFFF0);
        send(OP_OPIMM, 3'b111, 7'd0, 64'hF0F0, 64'd0, 64'h0FF0);
        chk("andi", bus.alu_data_mem_o, 64'h00F0);

        setup(OP_STORE, 3'b011, 7'd0, 64'h1000, 64'hAB, -64'sd8, 5'd9, 1'b1, 1'b1);
        tick();
        bus.valid_ex_i = 1'b0;
        chk("st_alu", bus.alu_data_mem_o, 64'hFF8);
        chk("st_data", bus.store_data_mem_o, 64'hAB);
        chk("st_wen", {63'd0, bus.mem_w_en_mem_o}, 64'd1);
        chk("st_ren", {63'd0, bus.mem_r_en_mem_o}, 64'd0);
        chk("st_rden", {63'd0, bus.rd_en_mem_o}, 64'd1);
        chk("st_rd", {59'd0, bus.rd_addr_mem_o}, 64'd9);
        chk("st_f3", {61'd0, bus.funct3_mem_o}, 64'd3);

        setup(OP_LOAD, 3'b100, 7'd0, 64'h2000, 64'd0, 64'h10, 5'd4, 1'b1, 1'b0);
        tick();
        bus.valid_ex_i = 1'b0;
        chk("ld_alu", bus.alu_data_mem_o, 64'h2010);
        chk("ld_ren", {63'd0, bus.mem_r_en_mem_o}, 64'd1);
        chk("ld_f3", {61'd0, bus.funct3_mem_o}, 64'd4);

        setup(7'b1111111, 3'b010, 7'd0, 64'h55, 64'h66, 64'h77, 5'd17, 1'b0, 1'b0);
        tick();
        bus.valid_ex_i = 1'b0;
        chk("unk_alu", bus.alu_data_mem_o, 64'd0);
        chk("unk_store", bus.store_data_mem_o, 64'h66);
        chk("unk_rd", {59'd0, bus.rd_addr_mem_o}, 64'd17);

`ifndef CPRV_EX_MUL_EN
        send(OP_OP, 3'b000, 7'b0000001, 64'd3, -64'sd4, 64'd0);
        chk("nomul_add", bus.alu_data_mem_o, 64'hFFFF_FFFF_FFFF_FFFF);
`endif

        // Backpressure: result held while MEM stalls, next accepted on release
        send(OP_OP, 3'b000, 7'd0, 64'd1, 64'd2, 64'd0);
        bus.ready_mem_i = 1'b0;
        setup(OP_OP, 3'b100, 7'd0, 64'hF0, 64'hFF, 64'd0, 5'd2, 1'b1, 1'b0);
        #1;
        chk("bp_ready", {63'd0, bus.ready_ex_o}, 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_alu", bus.alu_data_mem_o, 64'd3);
            chk("bp_valid", {63'd0, bus.valid_mem_o}, 64'd1);
            chk("bp_rd", {59'd0, bus.rd_addr_mem_o}, 64'd1);
        end
        bus.ready_mem_i = 1'b1;
        #1;
        chk("bp_release_ready", {63'd0, bus.ready_ex_o}, 64'd1);
        tick();
        bus.valid_ex_i = 1'b0;
        chk("bp_next_alu", bus.alu_data_mem_o, 64'h0F);
        chk("bp_next_valid", {63'd0, bus.valid_mem_o}, 64'd1);
        tick();

`ifdef CPRV_EX_MUL_EN
        begin
            int ready_low = 0;
            int saw_valid = 0;
            send(OP_OP, 3'b000, 7'b0000001, 64'd3, -64'sd4, 64'd0);
            chk("mul_valid_n", {63'd0, bus.valid_mem_o}, 64'd0);
            for (int i = 0; i < 64; i++) begin
                if (bus.ready_ex_o === 1'b0) ready_low++;
                tick();
            end
            if (bus.ready_ex_o === 1'b0) ready_low++;
            chk("mul_busy_cycles", 64'(ready_low), 64'd65);
            tick();
            chk("mul_alu", bus.alu_data_mem_o, 64'hFFFF_FFFF_FFFF_FFF4);
            chk("mul_valid", {63'd0, bus.valid_mem_o}, 64'd1);
            chk("mul_ready_after", {63'd0, bus.ready_ex_o}, 64'd1);
            tick();

            send(OP_OP, 3'b000, 7'b0000001, 64'd3, -64'sd4, 64'd0);
            for (int i = 0; i < 9; i++) tick();
            rst = 1'b1;
            #3 rst = 1'b0;
            for (int i = 0; i < 70; i++) begin
                if (bus.valid_mem_o === 1'b1) saw_valid++;
                tick();
            end
            chk("mul_abort_valid", 64'(saw_valid), 64'd0);
            chk("mul_abort_ready", {63'd0, bus.ready_ex_o}, 64'd1);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/cprv_ex_stage.md
CPRV_EX_STAGE -- requirements
Module: cprv_ex_stage

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, giving the operand and result width.
REQ-002 clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 valid_ex_i  in  1  ID stage presents an instruction.
REQ-005 ready_ex_o  out  1  EX accepts the instruction this cycle.
REQ-006 rs1_data_ex_i  in  DATA_WIDTH  rs1 operand.
REQ-007 rs2_data_ex_i  in  DATA_WIDTH  rs2 operand, also the store data.
REQ-008 rd_addr_ex_i  in  5  destination register.
REQ-009 rd_en_ex_i  in  1  destination write enable.
REQ-010 imm_data_ex_i  in  DATA_WIDTH  sign-extended immediate.
REQ-011 opcode_ex_i / funct3_ex_i / funct7_ex_i  in  7/3/7  instruction fields.
REQ-012 mem_w_en_ex_i  in  1  store flag.
REQ-013 valid_mem_o  out  1  MEM-stage payload valid.
REQ-014 ready_mem_i  in  1  MEM stage accepts.
REQ-015 alu_data_mem_o  out  DATA_WIDTH  ALU result, or load/store address.
REQ-016 store_data_mem_o  out  DATA_WIDTH  registered rs2.
REQ-017 rd_addr_mem_o / rd_en_mem_o  out  5/1  registered rd_addr_ex_i / rd_en_ex_i.
REQ-018 mem_w_en_mem_o / mem_r_en_mem_o / funct3_mem_o  out  1/1/3  store flag, load flag (opcode==LOAD), funct3.

Function
REQ-019 cke = ~valid_mem_o | ready_mem_i; ready_ex_o = cke & (state==IDLE); a transfer occurs when valid_ex_i & ready_ex_o.
REQ-020 All _mem_o outputs SHALL be registers; on cke, valid_mem_o <= (transfer & ~mul) | (state==DONE); when cke=0, all output registers hold.
REQ-021 Non-MUL latency: a transfer at edge N SHALL make the result visible after edge N; back-to-back transfers SHALL sustain 1 instruction per cycle while ready_mem_i=1.
REQ-022 OP/OP_IMM (operand B = rs2 or imm): funct3 000 ADD (SUB when OP & funct7[5]), 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL (SRA when funct7[5]), 110 OR, 111 AND; shamt = B[5:0].
REQ-023 OP_32/OP_IMM_32: ADDW/SUBW/SLLW/SRLW/SRAW on the low 32 bits with shamt B[4:0]; the 32-bit result SHALL be sign-extended to 64; other funct3 values give 0.
REQ-024 LOAD/STORE: alu_data = rs1 + imm, modulo 2^64.
REQ-025 Any other opcode SHALL give alu_data = 0, with the remaining fields passed through unchanged.
REQ-026 Sign rules: ADD/SUB wrap modulo 2^64; SLT is signed; SLTU is unsigned; results are 0 or 1.

Reset
REQ-027 While rst=1: valid_mem_o=0, all data outputs 0, state=IDLE, iteration counter 0; ready_ex_o follows REQ-019 (=1).
REQ-028 Reset asserted mid-multiply SHALL abort the multiply; no result is emitted.

Configuration
REQ-029 Macro CPRV_EX_MUL_EN defined: OP or OP_32 with funct7=0000001 and funct3=000 (MUL/MULW) SHALL run an iterative shift-add multiplier through FSM IDLE->BUSY (on transfer) ->DONE (after 64 iterations for MUL, 32 for MULW, one per edge) ->IDLE (on cke, loading the result).
REQ-030 Multiply results: the low 64 product bits; MULW is sign-extended from bit 31; other funct3 with funct7=0000001 give result 0. Macro undefined: no FSM (state is constant IDLE); funct7=0000001 decodes per REQ-022/023 (funct7[5]=0 -> ADD/ADDW).

Verification
REQ-031 OP ADD, rs1=5, rs2=-7 -> alu_data=0xFFFFFFFFFFFFFFFE, valid_mem_o=1 the next cycle; then SUB -> 12.
REQ-032 OP_IMM_32 SRAIW, rs1=0x0000000080000000, imm=4 -> 0xFFFFFFFFF8000000; SLTU, rs1=-1, rs2=1 -> 0.
REQ-033 STORE, rs1=0x1000, imm=-8, rs2=0xAB -> alu=0xFF8, store_data=0xAB, mem_w_en_mem_o=1, rd_en passed through.
REQ-034 ready_mem_i=0 with valid_mem_o=1 -> ready_ex_o=0 and outputs stable for 3 cycles; on release, the next instruction is accepted the same cycle.
REQ-035 CPRV_EX_MUL_EN: MUL 3 x -4, accepted at edge N -> ready_ex_o=0 through N+65, result 0xFFFFFFFFFFFFFFF4 valid after N+65; rst pulsed at N+10 -> no output, IDLE.
